// File: rtl/kbd_port_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// kbd_port_ctrl_pkg
// Shared constants and types for the keyboard port controller:
//   - default PicoBlaze port addresses (data / status / control)
//   - control-register and status-register bit positions
//   - IRQ state encoding and the packed status byte layout
// No ports (package).
// -----------------------------------------------------------------------------
package kbd_port_ctrl_pkg;

    localparam int         DEPTH_LOG2_DEF = 2;
    localparam logic [7:0] DATA_PORT_DEF  = 8'h0A;
    localparam logic [7:0] STAT_PORT_DEF  = 8'h0B;
    localparam logic [7:0] CTRL_PORT_DEF  = 8'h0C;

    // Control-write bit positions
    localparam int CTRL_IRQ_EN_BIT  = 0;
    localparam int CTRL_FLUSH_BIT   = 1;
    localparam int CTRL_OVF_CLR_BIT = 2;

    // Status-read bit positions
    localparam int STAT_NOT_EMPTY_BIT = 0;
    localparam int STAT_FULL_BIT      = 1;
    localparam int STAT_OVERFLOW_BIT  = 2;
    localparam int STAT_COUNT_LSB     = 4;
    localparam int STAT_IRQ_EN_BIT    = 7;

    typedef enum logic [1:0] {
        IRQ_IDLE    = 2'd0,
        IRQ_ASSERT  = 2'd1,
        IRQ_SERVICE = 2'd2
    } irq_state_e;

    // Status byte as seen by the CPU, MSB first.
    typedef struct packed {
        logic       irq_en;
        logic [2:0] count;
        logic       reserved;
        logic       overflow;
        logic       full;
        logic       not_empty;
    } status_t;

endpackage

// File: rtl/kbd_port_ctrl_if.sv
// -----------------------------------------------------------------------------
// kbd_port_ctrl_if
// PicoBlaze I/O bus as seen by the keyboard port controller.
//   port_id       CPU -> ctrl  8  port address
//   read_strobe   CPU -> ctrl  1  INPUT strobe
//   write_strobe  CPU -> ctrl  1  OUTPUT strobe
//   out_port      CPU -> ctrl  8  write data
//   interrupt_ack CPU -> ctrl  1  interrupt acknowledge
//   in_port       ctrl -> CPU  8  registered read data
//   interrupt     ctrl -> CPU  1  interrupt request
// Modports: master = CPU side, slave = controller side.
// -----------------------------------------------------------------------------
interface kbd_port_ctrl_if;

    logic [7:0] port_id;
    logic       read_strobe;
    logic       write_strobe;
    logic [7:0] out_port;
    logic       interrupt_ack;
    logic [7:0] in_port;
    logic       interrupt;

    modport master (
        output port_id, read_strobe, write_strobe, out_port, interrupt_ack,
        input  in_port, interrupt
    );

    modport slave (
        input  port_id, read_strobe, write_strobe, out_port, interrupt_ack,
        output in_port, interrupt
    );

endinterface

// File: rtl/kbd_port_ctrl_code_fifo.sv
// -----------------------------------------------------------------------------
// kbd_code_fifo
// Synchronous FIFO of 8-bit key codes with push, pop and flush.
//   clk, reset  clock, async active-high reset
//   push, din   write request and data
//   pop         read request (ignored when empty)
//   flush       empties the FIFO; overrides push and pop
//   dout        head entry (combinational, undefined content when empty)
//   full, empty, count  occupancy (count range 0..DEPTH)
//   popped      a pop was actually performed this cycle
//   dropped     a push was refused because the FIFO was full with no pop
// -----------------------------------------------------------------------------
module kbd_code_fifo #(
    parameter int DEPTH_LOG2 = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic [7:0]            din,
    input  logic                  pop,
    input  logic                  flush,
    output logic [7:0]            dout,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  popped,
    output logic                  dropped
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CW    = DEPTH_LOG2 + 1;

    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic                  do_push;

    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));
    assign dout  = mem[rd_ptr];

    // A full FIFO still accepts a push when a pop frees the head slot in the
    // same cycle; flush discards both.
    assign popped  = pop & ~empty & ~flush;
    assign do_push = push & ~flush & (~full | popped);
    assign dropped = push & ~flush & full & ~popped;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of block ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (popped)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, popped})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: the storage array is deliberately not reset; the pointers and
    // count define which entries are valid, so stale contents are harmless.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/kbd_port_ctrl.sv
// -----------------------------------------------------------------------------
// kbd_port_ctrl
// Buffers released-key codes from the PS/2 decoder and serves them to a
// PicoBlaze over its I/O bus, with status/control ports and an interrupt.
//   clk            system clock
//   reset          asynchronous, active-high reset
//   got_code_tick  one-cycle push request, code_in valid
//   code_in        key code from decoder
//   bus (slave)    PicoBlaze bus: port_id, read/write strobes, out_port,
//                  interrupt_ack in; in_port, interrupt out
// Ports: DATA_PORT reads (and pops) the head code, STAT_PORT reads status,
// CTRL_PORT write sets irq_en (bit0), flushes (bit1), clears overflow (bit2).
// -----------------------------------------------------------------------------
module kbd_port_ctrl
    import kbd_port_ctrl_pkg::*;
#(
    parameter int         DEPTH_LOG2 = DEPTH_LOG2_DEF,
    parameter logic [7:0] DATA_PORT  = DATA_PORT_DEF,
    parameter logic [7:0] STAT_PORT  = STAT_PORT_DEF,
    parameter logic [7:0] CTRL_PORT  = CTRL_PORT_DEF
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           got_code_tick,
    input  logic [7:0]     code_in,
    kbd_port_ctrl_if.slave bus
);

    logic                data_sel;
    logic                stat_sel;
    logic                ctrl_wr;
    logic                flush;
    logic                ovf_clr;
    logic                pop_req;

    logic [7:0]          head;
    logic                full;
    logic                empty;
    logic [DEPTH_LOG2:0] count;
    logic                popped;
    logic                dropped;

    logic [7:0]          in_port_q;
    logic                rd_valid;
    logic [7:0]          rd_next;
    logic                overflow;
    logic                irq_en;
    status_t             status;

    irq_state_e          irq_state;
    logic                irq_q;

    assign data_sel = (bus.port_id == DATA_PORT);
    assign stat_sel = (bus.port_id == STAT_PORT);
    assign ctrl_wr  = bus.write_strobe & (bus.port_id == CTRL_PORT);
    assign flush    = ctrl_wr & bus.out_port[CTRL_FLUSH_BIT];
    assign ovf_clr  = ctrl_wr & bus.out_port[CTRL_OVF_CLR_BIT];

    // rd_valid remembers that the address cycle saw a real code, so a code
    // arriving into an empty FIFO during that cycle is not consumed unseen.
    assign pop_req  = bus.read_strobe & data_sel & rd_valid;

    kbd_code_fifo #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (got_code_tick),
        .din     (code_in),
        .pop     (pop_req),
        .flush   (flush),
        .dout    (head),
        .full    (full),
        .empty   (empty),
        .count   (count),
        .popped  (popped),
        .dropped (dropped)
    );

    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        status           = '0;
        status.irq_en    = irq_en;
        status.count     = 3'(count);
        status.overflow  = overflow;
        status.full      = full;
        status.not_empty = ~empty;

        rd_next = 8'h00;
        if (data_sel) begin
            rd_next = empty ? 8'h00 : head;
        end else if (stat_sel) begin
            rd_next = status;
        end
    end

    // Read data is registered from port_id; the CPU holds port_id for two
    // cycles, so the value is ready when it samples in the strobe cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            in_port_q <= 8'h00;
            rd_valid  <= 1'b0;
        end else begin
            in_port_q <= rd_next;
            rd_valid  <= data_sel & ~empty;
        end
    end

    // Overflow is sticky; an explicit clear beats a same-cycle drop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow <= 1'b0;
            irq_en   <= 1'b0;
        end else begin
            if (ovf_clr)      overflow <= 1'b0;
            else if (dropped) overflow <= 1'b1;
            if (ctrl_wr)      irq_en   <= bus.out_port[CTRL_IRQ_EN_BIT];
        end
    end

    // Interrupt FSM. interrupt is high only in IRQ_ASSERT and is registered
    // together with the state. A flush in IDLE suppresses assertion so a
    // FIFO that is being emptied never raises a request.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_state <= IRQ_IDLE;
            irq_q     <= 1'b0;
        end else begin
            case (irq_state)
                IRQ_IDLE: begin
                    if (irq_en & ~empty & ~flush) begin
                        irq_state <= IRQ_ASSERT;
                        irq_q     <= 1'b1;
                    end
                end
                IRQ_ASSERT: begin
                    if (flush | ~irq_en) begin
                        irq_state <= IRQ_IDLE;
                        irq_q     <= 1'b0;
                    end else if (bus.interrupt_ack) begin
                        irq_state <= IRQ_SERVICE;
                        irq_q     <= 1'b0;
                    end
                end
                IRQ_SERVICE: begin
                    if (popped | flush) begin
                        irq_state <= IRQ_IDLE;
                    end
                end
                default: begin
                    irq_state <= IRQ_IDLE;
                    irq_q     <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_port   = in_port_q;
    assign bus.interrupt = irq_q;

endmodule
